// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment readback path.
//   - SEG_0..SEG_F : active-low glyphs (bit0=a .. bit6=g) produced by the
//                    board's hex-to-segment driver; SEG_BLANK is all off.
//   - state_t      : frame-reader assembly state machine encoding.
//   - idx_width()  : width of a digit index for a given digit count.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_ASSEMBLE = 2'd0,
        ST_COMPARE  = 2'd1,
        ST_PUBLISH  = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // A single-digit frame still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_frame_reader_if.sv
// seg7_frame_reader_if: display-bus snoop inputs and the published-frame
// valid/ready output of the frame reader.
//   seg_n/seg_sel/seg_strobe : multiplexed display bus (one digit per strobe)
//   out_valid/out_ready      : publish handshake
//   out_word/out_err         : published hex word and per-digit glyph errors
//   busy                     : partial frame in progress
// Modports: slave = the reader, master = the bus driver / frame consumer.
interface seg7_frame_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [2:0]              seg_sel;
    logic                    seg_strobe;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] out_word;
    logic [NUM_DIGITS-1:0]   out_err;
    logic                    busy;

    modport slave (
        input  seg_n, seg_sel, seg_strobe, out_ready,
        output out_valid, out_word, out_err, busy
    );

    modport master (
        output seg_n, seg_sel, seg_strobe, out_ready,
        input  out_valid, out_word, out_err, busy
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: inverse of the hex-to-segment driver.
//   seg_n  in  7 : active-low segment pattern, bit0=a .. bit6=g
//   nibble out 4 : decoded hex value (0 when the pattern is not a glyph)
//   err    out 1 : pattern is not one of the 16 hex glyphs (blank included)
// Purely combinational.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (seg_n)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: err    = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_frame_reader.sv
// seg7_frame_reader: snoops a time-multiplexed seven-segment bus, rebuilds
// NUM_DIGITS-digit frames and publishes a frame once it has been seen
// identically STABLE_FRAMES times in a row.
//   clock     in  : system clock, rising edge
//   reset     in  : asynchronous, active-high
//   bus       if  : seg7_frame_reader_if.slave (snoop inputs, publish output)
//   overrun   out : only with SEG7_FRAME_READER_OVERRUN_EN defined; sticky flag
//                   for a dropped publish or a digit-sequence break mid-frame
// Parameters: NUM_DIGITS (1..8), STABLE_FRAMES (>=1).
module seg7_frame_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic clock,
    input  logic reset,
    seg7_frame_reader_if.slave bus
`ifdef SEG7_FRAME_READER_OVERRUN_EN
    ,
    output logic overrun
`endif
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);

    typedef logic [NUM_DIGITS-1:0][3:0] word_t;
    typedef logic [NUM_DIGITS-1:0]      err_t;

    state_t        state, state_nxt;
    logic [IW-1:0] expected;
    word_t         asm_word, asm_word_ins;
    err_t          asm_err, asm_err_ins;
    word_t         snap_word, prev_word, last_word, out_word_q;
    err_t          snap_err, prev_err, last_err, out_err_q;
    logic [SW-1:0] stable_cnt, stable_nxt;
    logic          pub_once, out_valid_q;

    logic [3:0]    dec_nibble;
    logic          dec_err;
    logic          sel_hit, frame_done;
    logic          frame_eq, frame_new, pub_cond, pub_fire;

    seg7_glyph_decode u_dec (
        .seg_n  (bus.seg_n),
        .nibble (dec_nibble),
        .err    (dec_err)
    );

    // ---------------------------------------------------------------
    // Digit assembly. Runs in every state: the compare works on the
    // snapshot, so a strobe in the COMPARE cycle already starts the
    // next frame at digit 0.
    // ---------------------------------------------------------------
    assign sel_hit    = (bus.seg_sel == 3'(expected));
    assign frame_done = bus.seg_strobe && sel_hit && (expected == LAST_IDX);

    // Assembly registers with the current strobe's digit merged in; this is
    // also the snapshot value when the strobe completes the frame.
    always_comb begin
        asm_word_ins = asm_word;
        asm_err_ins  = asm_err;
        if (sel_hit) begin
            asm_word_ins[expected] = dec_nibble;
            asm_err_ins[expected]  = dec_err;
        end else if (bus.seg_sel == 3'd0) begin
            // Out-of-sequence digit 0 restarts the frame rather than waiting
            // a whole scan for the next one.
            asm_word_ins[0] = dec_nibble;
            asm_err_ins[0]  = dec_err;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            expected  <= '0;
            asm_word  <= '0;
            asm_err   <= '0;
            snap_word <= '0;
            snap_err  <= '0;
        end else if (bus.seg_strobe) begin
            asm_word <= asm_word_ins;
            asm_err  <= asm_err_ins;
            if (sel_hit)
                expected <= (expected == LAST_IDX) ? '0 : expected + 1'b1;
            else if (bus.seg_sel == 3'd0)
                expected <= IW'(1);
            else
                expected <= '0;
            if (frame_done) begin
                snap_word <= asm_word_ins;
                snap_err  <= asm_err_ins;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stability tracking and publish decision (COMPARE cycle only).
    // ---------------------------------------------------------------
    assign frame_eq   = ({snap_word, snap_err} == {prev_word, prev_err});
    assign stable_nxt = !frame_eq                  ? SW'(1) :
                        (stable_cnt == STABLE_MAX) ? STABLE_MAX :
                                                     stable_cnt + 1'b1;
    assign frame_new  = !pub_once || ({snap_word, snap_err} != {last_word, last_err});
    assign pub_cond   = (state == ST_COMPARE) && (stable_nxt == STABLE_MAX) && frame_new;
    // A frame that qualifies while the previous one is still unacknowledged
    // is dropped; last_* stays put so the next stable frame retries it.
    assign pub_fire   = pub_cond && !out_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            prev_word  <= '0;
            prev_err   <= '0;
        end else if (state == ST_COMPARE) begin
            stable_cnt <= stable_nxt;
            if (!frame_eq) begin
                prev_word <= snap_word;
                prev_err  <= snap_err;
            end
        end
    end

    // Output register: loaded at the end of COMPARE so out_valid shows up
    // two cycles after the completing strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_err_q   <= '0;
            last_word   <= '0;
            last_err    <= '0;
            pub_once    <= 1'b0;
        end else if (pub_fire) begin
            out_valid_q <= 1'b1;
            out_word_q  <= snap_word;
            out_err_q   <= snap_err;
            last_word   <= snap_word;
            last_err    <= snap_err;
            pub_once    <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Assembly state machine. A completed frame always takes priority
    // and forces a COMPARE cycle (back-to-back for NUM_DIGITS=1).
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_ASSEMBLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ASSEMBLE: begin
                if (frame_done) state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (frame_done)       state_nxt = ST_COMPARE;
                else if (pub_fire)    state_nxt = ST_PUBLISH;
                else if (out_valid_q) state_nxt = ST_HOLD;
                else                  state_nxt = ST_ASSEMBLE;
            end
            ST_PUBLISH: begin
                state_nxt = frame_done ? ST_COMPARE : ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_done)        state_nxt = ST_COMPARE;
                else if (!out_valid_q) state_nxt = ST_ASSEMBLE;
            end
            default: state_nxt = ST_ASSEMBLE;
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (expected != '0);

`ifdef SEG7_FRAME_READER_OVERRUN_EN
    logic pub_drop, seq_err;

    assign pub_drop = pub_cond && out_valid_q;
    // Only a break inside a frame counts; stray digits while idle do not.
    assign seq_err  = bus.seg_strobe && !sel_hit && (expected != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    overrun <= 1'b0;
        else if (pub_drop || seq_err) overrun <= 1'b1;
    end
`endif

endmodule
